// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared cache geometry and miss-controller state encoding
package cache_pkg;

   localparam int ADDR_W          = 16;
   localparam int WORDS_PER_BLOCK = 8;
   localparam int OFFSET_W        = 4;
   localparam int CNT_W           = 4;

   localparam logic [ADDR_W-1:0] BLOCK_MASK = {ADDR_W{1'b1}} << OFFSET_W;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      FILL = 2'b01,
      TAG  = 2'b10
   } state_t;

endpackage

// File: rtl/fill_counter.sv
// rtl/fill_counter.sv - word counter with synchronous clear and increment enable
module fill_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc) begin
         count_d = count_q + W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/cache_fill_fsm.sv
// rtl/cache_fill_fsm.sv - cache miss controller streaming one block from main memory
module cache_fill_fsm #(
   parameter int ADDR_W          = cache_pkg::ADDR_W,
   parameter int WORDS_PER_BLOCK = cache_pkg::WORDS_PER_BLOCK,
   parameter int OFFSET_W        = cache_pkg::OFFSET_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              miss_detected,
   input  logic [ADDR_W-1:0] miss_address,
   input  logic              memory_data_valid,
   input  logic [15:0]       memory_data,
   output logic              fsm_busy,
   output logic              mem_read_en,
   output logic [ADDR_W-1:0] memory_address,
   output logic              write_data_array,
   output logic [2:0]        data_word_sel,
   output logic [15:0]       data_word,
   output logic              write_tag_array,
   output logic              fill_done
);

   import cache_pkg::*;

   localparam logic [ADDR_W-1:0] BLK_MASK = {ADDR_W{1'b1}} << OFFSET_W;
   localparam logic [CNT_W-1:0]  WPB      = CNT_W'(WORDS_PER_BLOCK);
   localparam logic [CNT_W-1:0]  LAST     = CNT_W'(WORDS_PER_BLOCK - 1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] base_addr_q, base_addr_d;
   logic [ADDR_W-1:0] memory_address_q, memory_address_d;
   logic              mem_read_en_q, mem_read_en_d;
   logic              write_tag_array_q, write_tag_array_d;

   logic [CNT_W-1:0]  issue_cnt, recv_cnt, issue_cnt_nxt;
   logic              cnt_clr, issue_inc, recv_inc;

   fill_counter #(.W(CNT_W)) u_issue_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (cnt_clr),
      .inc   (issue_inc),
      .count (issue_cnt)
   );

   fill_counter #(.W(CNT_W)) u_recv_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (cnt_clr),
      .inc   (recv_inc),
      .count (recv_cnt)
   );

   always_comb begin
      state_d     = state_q;
      base_addr_d = base_addr_q;
      cnt_clr     = 1'b0;
      issue_inc   = 1'b0;
      recv_inc    = 1'b0;
      case (state_q)
         IDLE: begin
            if (miss_detected) begin
               base_addr_d = miss_address & BLK_MASK;
               cnt_clr     = 1'b1;
               state_d     = FILL;
            end
         end
         FILL: begin
            issue_inc = (issue_cnt < WPB);
            recv_inc  = memory_data_valid;
            if (memory_data_valid && (recv_cnt == LAST)) begin
               state_d = TAG;
            end
         end
         TAG: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Issue-side outputs are registered, so they are derived from next-cycle state and count.
      issue_cnt_nxt     = cnt_clr ? '0 : issue_cnt + CNT_W'(issue_inc);
      mem_read_en_d     = (state_d == FILL) && (issue_cnt_nxt < WPB);
      memory_address_d  = mem_read_en_d ? base_addr_d + ADDR_W'({issue_cnt_nxt, 1'b0}) : '0;
      write_tag_array_d = (state_d == TAG);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q           <= IDLE;
         base_addr_q       <= '0;
         mem_read_en_q     <= 1'b0;
         memory_address_q  <= '0;
         write_tag_array_q <= 1'b0;
      end else begin
         state_q           <= state_d;
         base_addr_q       <= base_addr_d;
         mem_read_en_q     <= mem_read_en_d;
         memory_address_q  <= memory_address_d;
         write_tag_array_q <= write_tag_array_d;
      end
   end

   // Busy is combinational so the pipeline stalls in the very cycle the miss appears.
   assign fsm_busy         = rst_n & ((state_q != IDLE) | miss_detected);
   assign mem_read_en      = mem_read_en_q;
   assign memory_address   = memory_address_q;
   assign write_data_array = (state_q == FILL) & memory_data_valid;
   assign data_word_sel    = write_data_array ? recv_cnt[2:0] : 3'd0;
   assign data_word        = write_data_array ? memory_data : 16'd0;
   assign write_tag_array  = write_tag_array_q;
   assign fill_done        = write_tag_array_q;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb/tb_cache_fill_fsm.sv - self-checking bench for cache_fill_fsm
module tb_cache_fill_fsm;

   logic        clk;
   logic        rst_n;
   logic        miss_detected;
   logic [15:0] miss_address;
   logic        memory_data_valid;
   logic [15:0] memory_data;
   logic        fsm_busy;
   logic        mem_read_en;
   logic [15:0] memory_address;
   logic        write_data_array;
   logic [2:0]  data_word_sel;
   logic [15:0] data_word;
   logic        write_tag_array;
   logic        fill_done;

   int checks;
   int failures;

   cache_fill_fsm dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .miss_detected     (miss_detected),
      .miss_address      (miss_address),
      .memory_data_valid (memory_data_valid),
      .memory_data       (memory_data),
      .fsm_busy          (fsm_busy),
      .mem_read_en       (mem_read_en),
      .memory_address    (memory_address),
      .write_data_array  (write_data_array),
      .data_word_sel     (data_word_sel),
      .data_word         (data_word),
      .write_tag_array   (write_tag_array),
      .fill_done         (fill_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst_n;
      logic        miss;
      logic [15:0] maddr;
      logic        valid;
      logic [15:0] mdata;
      logic        busy;
      logic        rd;
      logic [15:0] raddr;
      logic        wr;
      logic [2:0]  sel;
      logic [15:0] word;
      logic        tag;
   } vec_t;

   vec_t vecs[$];

   logic        s_miss  [0:63];
   logic        s_valid [0:63];
   logic [15:0] s_addr  [0:63];

   int rd_cyc[$], rd_adr[$], wr_cyc[$], wr_sel[$], wr_wrd[$], tag_cyc[$], busy_cyc[$];
   int e_rd_cyc[$], e_rd_adr[$], e_wr_cyc[$], e_wr_sel[$], e_wr_wrd[$], e_tag_cyc[$], e_busy_cyc[$];
   int done_err;
   int stray_addr;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic check_q(input string nm, input int got[$], input int exp[$]);
      check({nm, "_count"}, 64'(got.size()), 64'(exp.size()));
      for (int i = 0; i < exp.size(); i++) begin
         check($sformatf("%s[%0d]", nm, i), (i < got.size()) ? 64'(got[i]) : 64'hDEAD_BEEF_0000, 64'(exp[i]));
      end
   endtask

   task automatic clear_sched();
      for (int i = 0; i < 64; i++) begin
         s_miss[i]  = 1'b0;
         s_valid[i] = 1'b0;
         s_addr[i]  = 16'h0000;
      end
      e_rd_cyc.delete(); e_rd_adr.delete(); e_wr_cyc.delete(); e_wr_sel.delete();
      e_wr_wrd.delete(); e_tag_cyc.delete(); e_busy_cyc.delete();
   endtask

   // Expected activity of a fill whose miss is seen in cycle m with 3-cycle memory latency.
   task automatic exp_std(input int m, input logic [15:0] base);
      for (int i = 0; i < 8; i++) begin
         e_rd_cyc.push_back(m + 1 + i);
         e_rd_adr.push_back(int'(base + 16'(2 * i)));
      end
      for (int i = 0; i < 8; i++) begin
         e_wr_cyc.push_back(m + 4 + i);
         e_wr_sel.push_back(i);
         e_wr_wrd.push_back(int'(16'hD000 | 16'(m + 4 + i)));
      end
      e_tag_cyc.push_back(m + 12);
      for (int c = m; c <= m + 12; c++) e_busy_cyc.push_back(c);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      miss_detected = 1'b0;
      miss_address = 16'h0000;
      memory_data_valid = 1'b0;
      memory_data = 16'h0000;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic run(input int n);
      rd_cyc.delete(); rd_adr.delete(); wr_cyc.delete(); wr_sel.delete();
      wr_wrd.delete(); tag_cyc.delete(); busy_cyc.delete();
      done_err = 0;
      stray_addr = 0;
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         miss_detected     = s_miss[c];
         miss_address      = s_addr[c];
         memory_data_valid = s_valid[c];
         memory_data       = 16'hD000 | 16'(c);
         #1;
         if (mem_read_en) begin
            rd_cyc.push_back(c);
            rd_adr.push_back(int'(memory_address));
         end else if (memory_address != 16'h0000) begin
            stray_addr++;
         end
         if (write_data_array) begin
            wr_cyc.push_back(c);
            wr_sel.push_back(int'(data_word_sel));
            wr_wrd.push_back(int'(data_word));
         end
         if (write_tag_array) tag_cyc.push_back(c);
         if (fill_done !== write_tag_array) done_err++;
         if (fsm_busy) busy_cyc.push_back(c);
      end
   endtask

   task automatic compare_all(input string nm);
      check_q({nm, "_rd_cyc"}, rd_cyc, e_rd_cyc);
      check_q({nm, "_rd_addr"}, rd_adr, e_rd_adr);
      check_q({nm, "_wr_cyc"}, wr_cyc, e_wr_cyc);
      check_q({nm, "_wr_sel"}, wr_sel, e_wr_sel);
      check_q({nm, "_wr_word"}, wr_wrd, e_wr_wrd);
      check_q({nm, "_tag_cyc"}, tag_cyc, e_tag_cyc);
      check_q({nm, "_busy_cyc"}, busy_cyc, e_busy_cyc);
      check({nm, "_done_vs_tag"}, 64'(done_err), 64'd0);
      check({nm, "_stray_addr"}, 64'(stray_addr), 64'd0);
   endtask

   initial begin
      vec_t v;
      checks = 0;
      failures = 0;
      rst_n = 1'b0;
      miss_detected = 1'b0;
      miss_address = 16'h0000;
      memory_data_valid = 1'b0;
      memory_data = 16'h0000;

      // Reset vector: miss and valid asserted while rst_n is low must leave everything at 0.
      v = '{rst_n: 1'b0, miss: 1'b1, maddr: 16'h1236, valid: 1'b1, mdata: 16'hFFFF,
            busy: 1'b0, rd: 1'b0, raddr: 16'h0, wr: 1'b0, sel: 3'd0, word: 16'h0, tag: 1'b0};
      vecs.push_back(v);
      for (int i = 0; i < 5; i++) begin
         v = '{rst_n: 1'b1, miss: 1'b0, maddr: 16'hBEEF, valid: 1'(i % 2), mdata: 16'hFFFF,
               busy: 1'b0, rd: 1'b0, raddr: 16'h0, wr: 1'b0, sel: 3'd0, word: 16'h0, tag: 1'b0};
         vecs.push_back(v);
      end
      // Fill of 0x1236: issues cycles 1-8, data cycles 4-11, tag cycle 12, idle cycle 13.
      for (int c = 0; c <= 13; c++) begin
         v.rst_n = 1'b1;
         v.miss  = (c == 0);
         v.maddr = 16'h1236;
         v.valid = (c >= 4 && c <= 11);
         v.mdata = v.valid ? 16'hA000 + 16'(c) : 16'h7777;
         v.busy  = (c <= 12);
         v.rd    = (c >= 1 && c <= 8);
         v.raddr = v.rd ? 16'h1230 + 16'(2 * (c - 1)) : 16'h0000;
         v.wr    = v.valid;
         v.sel   = v.wr ? 3'(c - 4) : 3'd0;
         v.word  = v.wr ? v.mdata : 16'h0000;
         v.tag   = (c == 12);
         vecs.push_back(v);
      end

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         rst_n             = vecs[i].rst_n;
         miss_detected     = vecs[i].miss;
         miss_address      = vecs[i].maddr;
         memory_data_valid = vecs[i].valid;
         memory_data       = vecs[i].mdata;
         #1;
         check($sformatf("vec%0d", i),
               64'({fsm_busy, mem_read_en, memory_address, write_data_array, data_word_sel,
                    data_word, write_tag_array, fill_done}),
               64'({vecs[i].busy, vecs[i].rd, vecs[i].raddr, vecs[i].wr, vecs[i].sel,
                    vecs[i].word, vecs[i].tag, vecs[i].tag}));
      end

      // Irregular memory gaps.
      do_reset();
      clear_sched();
      s_miss[0] = 1'b1;
      s_addr[0] = 16'h1236;
      begin
         int vc[8] = '{4, 6, 7, 10, 11, 12, 15, 16};
         for (int i = 0; i < 8; i++) begin
            s_valid[vc[i]] = 1'b1;
            e_rd_cyc.push_back(i + 1);
            e_rd_adr.push_back(int'(16'h1230 + 16'(2 * i)));
            e_wr_cyc.push_back(vc[i]);
            e_wr_sel.push_back(i);
            e_wr_wrd.push_back(int'(16'hD000 | 16'(vc[i])));
         end
      end
      e_tag_cyc.push_back(17);
      for (int c = 0; c <= 17; c++) e_busy_cyc.push_back(c);
      run(20);
      compare_all("gaps");

      // Miss held throughout with the address changing mid-fill.
      do_reset();
      clear_sched();
      for (int c = 0; c < 16; c++) begin
         s_miss[c] = 1'b1;
         s_addr[c] = (c < 5) ? 16'h1236 : 16'h4000;
         s_valid[c] = (c >= 4 && c <= 11);
      end
      exp_std(0, 16'h1230);
      e_rd_cyc.push_back(14); e_rd_adr.push_back(int'(16'h4000));
      e_rd_cyc.push_back(15); e_rd_adr.push_back(int'(16'h4002));
      for (int c = 13; c < 16; c++) e_busy_cyc.push_back(c);
      run(16);
      compare_all("held_miss");

      // Asynchronous reset after five data words, then a fresh fill.
      do_reset();
      clear_sched();
      s_miss[0] = 1'b1;
      s_addr[0] = 16'h1236;
      for (int c = 4; c <= 8; c++) s_valid[c] = 1'b1;
      run(9);
      check("pre_reset_wr_count", 64'(wr_cyc.size()), 64'd5);
      @(negedge clk);
      miss_detected = 1'b1;
      memory_data_valid = 1'b1;
      memory_data = 16'h5555;
      #1;
      check("pre_reset_wr", 64'(write_data_array), 64'd1);
      check("pre_reset_sel", 64'(data_word_sel), 64'd5);
      #1;
      rst_n = 1'b0;
      #1;
      check("async_reset_outputs",
            64'({fsm_busy, mem_read_en, memory_address, write_data_array, data_word_sel,
                 data_word, write_tag_array, fill_done}),
            64'd0);
      #1;
      miss_detected = 1'b0;
      memory_data_valid = 1'b0;
      rst_n = 1'b1;
      clear_sched();
      s_miss[0] = 1'b1;
      s_addr[0] = 16'h00F2;
      for (int c = 4; c <= 11; c++) s_valid[c] = 1'b1;
      exp_std(0, 16'h00F0);
      run(14);
      compare_all("after_reset");

      // Back-to-back misses at the top and bottom of the address space.
      do_reset();
      clear_sched();
      s_miss[0] = 1'b1;
      s_addr[0] = 16'hFFF0;
      s_miss[13] = 1'b1;
      s_addr[13] = 16'h0000;
      for (int c = 4; c <= 11; c++) s_valid[c] = 1'b1;
      for (int c = 17; c <= 24; c++) s_valid[c] = 1'b1;
      exp_std(0, 16'hFFF0);
      begin
         int tmp_busy[$];
         exp_std(13, 16'h0000);
         tmp_busy = e_busy_cyc;
         e_busy_cyc = tmp_busy;
      end
      // exp_std appends per call, so rebuild the interleaved lists in cycle order.
      e_rd_cyc.delete(); e_rd_adr.delete(); e_wr_cyc.delete(); e_wr_sel.delete();
      e_wr_wrd.delete(); e_tag_cyc.delete(); e_busy_cyc.delete();
      exp_std(0, 16'hFFF0);
      exp_std(13, 16'h0000);
      run(28);
      compare_all("back_to_back");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
